demux1x8_tdm_rx: RTL

- Receive end of the 8:1 mux serial link. The transmitter multiplexes d7..d0 onto one line using a 3-bit select sequence s2s1s0 = 0..7.
- This block demultiplexes that serial stream back into 8 parallel outputs.
- It tracks the slot index with a counter, aligns to a frame-sync marker, double-buffers the frame and presents a registered 8-bit word with a one-cycle valid strobe.
- It sits directly downstream of the mux-based serializer in the datapath.

---
 rtl/demux1x8_tdm_rx_if.sv | 32 +++
 rtl/demux1x8_tdm_rx.sv | 133 +++++++++++++
 2 files changed

// File: rtl/demux1x8_tdm_rx_if.sv
// Serial-in / parallel-out bundle for the TDM demux receiver.
// Optional macro DEMUX_PARITY_EN widens slot to 4 bits and adds parity_err.
// master = stream source and result consumer, slave = demux receiver.
interface demux1x8_tdm_rx_if;
`ifdef DEMUX_PARITY_EN
   localparam int SLOT_W = 4;
`else
   localparam int SLOT_W = 3;
`endif

   logic              din;
   logic              bit_en;
   logic              frame_sync;
   logic [7:0]        d_out;
   logic              frame_valid;
   logic [SLOT_W-1:0] slot;
   logic              locked;
   logic              sync_err;
`ifdef DEMUX_PARITY_EN
   logic              parity_err;

   modport master (output din, bit_en, frame_sync,
                   input  d_out, frame_valid, slot, locked, sync_err, parity_err);
   modport slave  (input  din, bit_en, frame_sync,
                   output d_out, frame_valid, slot, locked, sync_err, parity_err);
`else
   modport master (output din, bit_en, frame_sync,
                   input  d_out, frame_valid, slot, locked, sync_err);
   modport slave  (input  din, bit_en, frame_sync,
                   output d_out, frame_valid, slot, locked, sync_err);
`endif
endinterface

// File: rtl/demux1x8_tdm_rx.sv
// Receive side of the 8:1 serial link: slot counter, frame-sync alignment,
// shadow register and registered 8-bit output word with a valid strobe.
// Optional macro DEMUX_PARITY_EN: 9-slot frame, slot 8 carries even parity.
//
// state  | meaning
// HUNT   | not aligned, waiting for frame_sync to mark slot 0
// ACTIVE | aligned, collecting bits into the shadow register (locked)
module demux1x8_tdm_rx #(
   parameter int MISS_LIMIT = 2,
   parameter int SEL_W      = 3
) (
   input logic               clk,
   input logic               rst_n,
   demux1x8_tdm_rx_if.slave  bus
);
`ifdef DEMUX_PARITY_EN
   localparam int            SW        = SEL_W + 1;
   localparam logic [SW-1:0] LAST_SLOT = SW'(2**SEL_W);
`else
   localparam int            SW        = SEL_W;
   localparam logic [SW-1:0] LAST_SLOT = SW'(2**SEL_W - 1);
`endif
   localparam logic [2:0]    MISS_MAX  = 3'(MISS_LIMIT);

   typedef enum logic {HUNT, ACTIVE} state_t;

   state_t        state, state_nxt;
   logic [SW-1:0] slot_q, slot_nxt;
   logic [2:0]    miss_q, miss_nxt, miss_inc;
   logic [7:0]    shadow_q, shadow_nxt;
   logic [7:0]    d_out_q, d_out_nxt;
   logic          fv_q, fv_nxt;
   logic          se_q, se_nxt;
   logic          locked_q;
   logic          pe_q, pe_nxt;

   assign miss_inc = miss_q + 3'd1;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= HUNT;
      else        state <= state_nxt;
   end

   // Next-state, slot/miss bookkeeping, shadow capture and frame completion.
   always_comb begin
      state_nxt  = state;
      slot_nxt   = slot_q;
      miss_nxt   = miss_q;
      shadow_nxt = shadow_q;
      d_out_nxt  = d_out_q;
      fv_nxt     = 1'b0;
      se_nxt     = 1'b0;
      pe_nxt     = 1'b0;
      if (bus.bit_en) begin
         case (state)
            HUNT: begin
               if (bus.frame_sync) begin
                  shadow_nxt[0] = bus.din;
                  slot_nxt      = SW'(1);
                  miss_nxt      = 3'd0;
                  state_nxt     = ACTIVE;
               end
            end
            ACTIVE: begin
               if (bus.frame_sync && slot_q != '0) begin
                  // Sync seen mid-frame: drop the partial frame, realign here.
                  se_nxt        = 1'b1;
                  shadow_nxt[0] = bus.din;
                  slot_nxt      = SW'(1);
                  miss_nxt      = 3'd0;
               end else if (slot_q == '0 && !bus.frame_sync && miss_inc == MISS_MAX) begin
                  state_nxt = HUNT;
                  slot_nxt  = '0;
                  miss_nxt  = 3'd0;
               end else begin
                  if (slot_q == '0)
                     miss_nxt = bus.frame_sync ? 3'd0 : miss_inc;
                  if (slot_q == LAST_SLOT) begin
`ifdef DEMUX_PARITY_EN
                     d_out_nxt = shadow_q;
                     pe_nxt    = (^shadow_q) ^ bus.din;
`else
                     d_out_nxt = {bus.din, shadow_q[6:0]};
`endif
                     fv_nxt    = 1'b1;
                     slot_nxt  = '0;
                  end else begin
                     shadow_nxt[slot_q[SEL_W-1:0]] = bus.din;
                     slot_nxt = slot_q + SW'(1);
                  end
               end
            end
            default: state_nxt = HUNT;
         endcase
      end
   end

   // Datapath and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_q   <= '0;
         miss_q   <= 3'd0;
         shadow_q <= 8'h00;
         d_out_q  <= 8'h00;
         fv_q     <= 1'b0;
         se_q     <= 1'b0;
         locked_q <= 1'b0;
         pe_q     <= 1'b0;
      end else begin
         slot_q   <= slot_nxt;
         miss_q   <= miss_nxt;
         shadow_q <= shadow_nxt;
         d_out_q  <= d_out_nxt;
         fv_q     <= fv_nxt;
         se_q     <= se_nxt;
         locked_q <= (state_nxt == ACTIVE);
         pe_q     <= pe_nxt;
      end
   end

   assign bus.d_out       = d_out_q;
   assign bus.frame_valid = fv_q;
   assign bus.slot        = slot_q;
   assign bus.locked      = locked_q;
   assign bus.sync_err    = se_q;
`ifdef DEMUX_PARITY_EN
   assign bus.parity_err  = pe_q;
`else
   logic unused_pe;
   assign unused_pe = pe_q;
`endif
endmodule
